// File: rtl/exmem_if.sv
// EX/MEM pipeline register bundle: execute-side inputs, memory-side outputs.
// master drives the execute side; slave is the register itself.
interface exmem_if;
  logic        en;
  logic        flush;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic        alu_zf;
  logic        alu_nf;
  logic        alu_vf;
  logic [4:0]  wsel_in;
  logic        regwen_in;
  logic        dren_in;
  logic        dwen_in;
  logic        ovf_chk_in;
  logic        halt_in;
  logic [31:0] store_in;
  logic [31:0] npc_in;

  logic        valid_out;
  logic [31:0] result_out;
  logic        zf_out;
  logic        nf_out;
  logic [4:0]  wsel_out;
  logic        regwen_out;
  logic        dren_out;
  logic        dwen_out;
  logic [31:0] store_out;
  logic [31:0] npc_out;
  logic        ovf_out;
  logic [31:0] epc_out;
  logic        halt_out;
  logic [31:0] retired_out;

  modport master (
    output en, flush, ex_valid,
    output alu_result, alu_zf, alu_nf, alu_vf,
    output wsel_in, regwen_in, dren_in, dwen_in,
    output ovf_chk_in, halt_in, store_in, npc_in,
    input  valid_out, result_out, zf_out, nf_out,
    input  wsel_out, regwen_out, dren_out, dwen_out,
    input  store_out, npc_out, ovf_out, epc_out,
    input  halt_out, retired_out
  );

  modport slave (
    input  en, flush, ex_valid,
    input  alu_result, alu_zf, alu_nf, alu_vf,
    input  wsel_in, regwen_in, dren_in, dwen_in,
    input  ovf_chk_in, halt_in, store_in, npc_in,
    output valid_out, result_out, zf_out, nf_out,
    output wsel_out, regwen_out, dren_out, dwen_out,
    output store_out, npc_out, ovf_out, epc_out,
    output halt_out, retired_out
  );
endinterface

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register with overflow trap capture,
// sticky halt and a saturating retired-instruction counter.
module exmem_reg (
  input  logic     CLK,
  input  logic     nRST,
  exmem_if.slave   bus
);

  logic        r_valid;
  logic [31:0] r_result;
  logic        r_zf;
  logic        r_nf;
  logic [4:0]  r_wsel;
  logic        r_regwen;
  logic        r_dren;
  logic        r_dwen;
  logic [31:0] r_store;
  logic [31:0] r_npc;
  logic        r_ovf;
  logic [31:0] r_epc;
  logic        r_halt;
  logic [31:0] r_retired;

  logic w_trap;
  logic w_keep;

  assign w_trap = bus.ex_valid & bus.ovf_chk_in & bus.alu_vf;
  // a trapping entry must not touch the register file or memory
  assign w_keep = bus.ex_valid & ~w_trap;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zf      <= 1'b0;
      r_nf      <= 1'b0;
      r_wsel    <= '0;
      r_regwen  <= 1'b0;
      r_dren    <= 1'b0;
      r_dwen    <= 1'b0;
      r_store   <= '0;
      r_npc     <= '0;
      r_ovf     <= 1'b0;
      r_epc     <= '0;
      r_halt    <= 1'b0;
      r_retired <= '0;
    end else if (r_halt) begin
      r_halt    <= 1'b1;
    end else if (bus.flush) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zf      <= 1'b0;
      r_nf      <= 1'b0;
      r_wsel    <= '0;
      r_regwen  <= 1'b0;
      r_dren    <= 1'b0;
      r_dwen    <= 1'b0;
      r_store   <= '0;
      r_npc     <= '0;
      r_ovf     <= 1'b0;
    end else if (bus.en) begin
      r_valid   <= bus.ex_valid;
      r_result  <= bus.alu_result;
      r_zf      <= bus.alu_zf;
      r_nf      <= bus.alu_nf;
      r_wsel    <= bus.wsel_in;
      r_regwen  <= w_keep & bus.regwen_in;
      r_dren    <= w_keep & bus.dren_in;
      r_dwen    <= w_keep & bus.dwen_in;
      r_store   <= bus.store_in;
      r_npc     <= bus.npc_in;
      r_ovf     <= w_trap;
      if (w_trap)
        r_epc   <= bus.npc_in;
      if (bus.ex_valid & bus.halt_in)
        r_halt  <= 1'b1;
      if (bus.ex_valid && r_retired != 32'hFFFF_FFFF)
        r_retired <= r_retired + 32'd1;
    end
  end

  assign bus.valid_out   = r_valid;
  assign bus.result_out  = r_result;
  assign bus.zf_out      = r_zf;
  assign bus.nf_out      = r_nf;
  assign bus.wsel_out    = r_wsel;
  assign bus.regwen_out  = r_regwen;
  assign bus.dren_out    = r_dren;
  assign bus.dwen_out    = r_dwen;
  assign bus.store_out   = r_store;
  assign bus.npc_out     = r_npc;
  assign bus.ovf_out     = r_ovf;
  assign bus.epc_out     = r_epc;
  assign bus.halt_out    = r_halt;
  assign bus.retired_out = r_retired;

endmodule

// File: doc/exmem_reg.md
EXMEM_REG -- requirements
Module: exmem_reg

Interface
REQ-001: Ports SHALL be: CLK  in  1  clock, rising-edge active; nRST  in  1  asynchronous active-low reset.
REQ-002: Handshake inputs SHALL be: en  in  1  pipeline advance; flush  in  1  squash incoming entry; ex_valid  in  1  execute stage holds a real instruction.
REQ-003: ALU-side inputs SHALL be: alu_result  in  32  ALU result; alu_zf, alu_nf, alu_vf  in  1 each  ALU zero/negative/overflow flags.
REQ-004: Control inputs SHALL be: wsel_in  in  5  destination register; regwen_in, dren_in, dwen_in  in  1 each  register write, data read, data write; ovf_chk_in  in  1  instruction traps on signed overflow (ADD/ADDI); halt_in  in  1  HALT instruction; store_in  in  32  store data; npc_in  in  32  PC+4.
REQ-005: Outputs SHALL be: valid_out  out  1  entry valid; result_out  out  32; zf_out, nf_out  out  1 each; wsel_out  out  5; regwen_out, dren_out, dwen_out  out  1 each; store_out, npc_out  out  32; ovf_out  out  1  entry trapped on overflow; epc_out  out  32  npc of the most recent trapped entry; halt_out  out  1  sticky halt; retired_out  out  32  count of valid entries captured.
REQ-006: All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-007: Each rising CLK edge SHALL apply exactly one action, in priority order: HALTED-hold, flush, capture, hold.
REQ-008: HALTED-hold: while halt_out=1, all registers SHALL hold, ignoring en and flush.
REQ-009: Flush: flush=1 SHALL load a bubble (valid_out, regwen_out, dren_out, dwen_out, ovf_out all 0; data fields 0) regardless of en.
REQ-010: Capture: en=1 with flush=0 SHALL load every *_in/alu_* field into the matching output, with valid_out=ex_valid.
REQ-011: Capture with ex_valid=0 SHALL force regwen_out, dren_out, dwen_out, ovf_out and halt capture to 0.
REQ-012: Hold: en=0 with flush=0 SHALL keep all outputs unchanged.
REQ-013: Overflow trap: capture with ex_valid=1, ovf_chk_in=1 and alu_vf=1 SHALL set ovf_out=1, force regwen_out, dren_out and dwen_out to 0, and load epc_out with npc_in.
REQ-014: epc_out SHALL change only on a trapping capture; ovf_out SHALL be 0 on any non-trapping capture or flush.
REQ-015: alu_vf SHALL be ignored when ovf_chk_in=0 (SUB, SLT, logical ops never trap).
REQ-016: A capture with ex_valid=1 and halt_in=1 SHALL set halt_out=1, which then stays 1 until nRST.
REQ-017: retired_out SHALL increment by 1 on each capture with ex_valid=1, including trapping and halt entries; it SHALL saturate at 32'hFFFFFFFF.
REQ-018: Flush and hold SHALL never change retired_out.
REQ-019: Latency SHALL be one cycle: inputs present at edge N appear on outputs after edge N.

Reset
REQ-020: nRST=0 SHALL immediately, independent of CLK, drive every output to 0, including halt_out, epc_out and retired_out.
REQ-021: Reset asserted mid-operation (including while halted) SHALL discard the current entry; the first capture after deassertion SHALL behave as from power-up.

Verification
REQ-022: Reset then en=1, ex_valid=1, alu_result=32'h0000_0005, wsel_in=5'd3, regwen_in=1 -> next cycle result_out=5, wsel_out=3, regwen_out=1, valid_out=1, retired_out=1.
REQ-023: Capture as above, then en=0 for 3 cycles with changing inputs -> outputs unchanged and retired_out=1 throughout.
REQ-024: en=1 and flush=1 together with valid ADD inputs -> valid_out=0, regwen_out=0, retired_out unchanged.
REQ-025: ADD with alu_result=32'h8000_0000, alu_vf=1, ovf_chk_in=1, regwen_in=1, npc_in=32'h0000_0104 -> ovf_out=1, regwen_out=0, epc_out=32'h104; same inputs with ovf_chk_in=0 -> ovf_out=0, regwen_out=1.
REQ-026: Capture halt_in=1, ex_valid=1, then en=1 and flush=1 pulses for 5 cycles -> halt_out=1 and all outputs frozen; assert nRST=0 between clock edges -> all outputs 0 immediately.
REQ-027: Preload retired_out near 32'hFFFFFFFF via back-to-back valid captures (or force) -> it holds at 32'hFFFFFFFF on further valid captures.
